// File: rtl/fifo_gray_pkg.sv
// Gray/binary pointer helpers shared by both ends of the async FIFO pointer crossing.
// Functions operate on a wide container; callers zero-extend narrower pointers.
package fifo_gray_pkg;

    localparam int DEF_PTR_WIDTH = 6;
    localparam int MAX_PTR_WIDTH = 32;

    typedef logic [MAX_PTR_WIDTH-1:0] ptr_t;

    // Zero-extended upper bits decode to zero, so narrower pointers decode correctly.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[MAX_PTR_WIDTH-1] = gray[MAX_PTR_WIDTH-1];
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic int unsigned gray_hamming(input ptr_t a, input ptr_t b);
        return $countones(a ^ b);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary decoder for a WIDTH-bit pointer.
module gray2bin
    import fifo_gray_pkg::*;
#(
    parameter int WIDTH = DEF_PTR_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(fifo_gray_pkg::gray2bin(ptr_t'(gray)));

endmodule

// File: rtl/gray2bin_sync.sv
// Receive side of the gray pointer crossing: synchroniser, binary decode, pointer advance.
// Optional step checker enabled by defining GRAY_STEP_CHECK_EN.
module gray2bin_sync
    import fifo_gray_pkg::*;
#(
    parameter int WIDTH       = DEF_PTR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_gray_async,
    output logic [WIDTH-1:0] data_gray_sync,
    output logic [WIDTH-1:0] data_bin,
    output logic [WIDTH-1:0] ptr_delta,
    output logic             bin_valid,
    output logic             step_err
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] bin_next;
    logic [CNT_W-1:0] fill_cnt;

    // Stage boundary: flip-flop synchroniser chain, no logic between stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
        end else begin
            sync_p[0] <= data_gray_async;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    assign data_gray_sync = sync_p[SYNC_STAGES-1];

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (data_gray_sync),
        .bin  (bin_next)
    );

    // Stage boundary: fill counter, valid rises once the chain holds post-reset samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt  <= '0;
            bin_valid <= 1'b0;
        end else if (!bin_valid) begin
            if (fill_cnt == CNT_W'(SYNC_STAGES)) begin
                bin_valid <= 1'b1;
            end else begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // Stage boundary: registered decode and modular advance; the refill jump is masked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_bin  <= '0;
            ptr_delta <= '0;
        end else begin
            data_bin  <= bin_next;
            ptr_delta <= bin_valid ? (bin_next - data_bin) : '0;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] sync_prev_p;
    logic             step_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_prev_p <= '0;
            step_err_r  <= 1'b0;
        end else begin
            sync_prev_p <= data_gray_sync;
            if (bin_valid &&
                gray_hamming(ptr_t'(data_gray_sync), ptr_t'(sync_prev_p)) > 1) begin
                step_err_r <= 1'b1;
            end
        end
    end

    assign step_err = step_err_r;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray2bin_sync.sv
// Directed bench for gray2bin_sync: reset, sweep, wrap, hold/jump, reset mid-stream.
module tb_gray2bin_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] din;
    logic [5:0] sync;
    logic [5:0] dbin;
    logic [5:0] delta;
    logic       vld;
    logic       serr;

    int checks = 0;
    int errors = 0;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [31:0] EXP_JUMP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_JUMP_ERR = 32'd0;
`endif

    always #5 clk = ~clk;

    gray2bin_sync #(
        .WIDTH       (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_gray_async (din),
        .data_gray_sync  (sync),
        .data_bin        (dbin),
        .ptr_delta       (delta),
        .bin_valid       (vld),
        .step_err        (serr)
    );

    function automatic logic [5:0] b2g(input int i);
        logic [5:0] v;
        v = i[5:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sync"},  32'(sync),  0);
        chk({tag, "_bin"},   32'(dbin),  0);
        chk({tag, "_delta"}, 32'(delta), 0);
        chk({tag, "_vld"},   32'(vld),   0);
        chk({tag, "_err"},   32'(serr),  0);
    endtask

    // Drives b2g(j) each cycle; optionally pulses rst mid-clock at iteration rst_at.
    task automatic sweep(input int last, input int rst_at);
        int base;
        int e;
        int ev;
        base = -1;
        for (int j = 0; j <= last; j++) begin
            din = b2g((j > 63) ? 63 : j);
            if (j == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check_zero("mid_rst");
                tick();
                rst  = 1'b0;
                base = j;
                continue;
            end
            tick();
            e = j - base;
            if (e <= 2) begin
                chk("sweep_vld_lo", 32'(vld), 0);
            end else begin
                ev = ((j - 2) > 63) ? 63 : (j - 2);
                chk("sweep_vld", 32'(vld), 1);
                chk("sweep_bin", 32'(dbin), ev);
                chk("sweep_delta", 32'(delta), (e == 3) ? 0 : 1);
                chk("sweep_err", 32'(serr), 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        din = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        check_zero("por");

        // Scenario 1: fill latency and asynchronous reset assertion
        rst = 1'b0;
        din = 6'b101010;
        tick();
        chk("fill_e1_vld", 32'(vld), 0);
        tick();
        chk("fill_e2_vld", 32'(vld), 0);
        tick();
        chk("fill_e3_vld", 32'(vld), 1);
        chk("fill_e3_bin", 32'(dbin), 51);
        chk("fill_e3_delta", 32'(delta), 0);
        chk("fill_e3_sync", 32'(sync), 32'b101010);
        #3 rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        rst = 1'b0;

        // Scenario 2: full sweep
        sweep(65, -1);

        // Scenario 3: wrap 62 -> 63 -> 0
        din = b2g(62);
        repeat (4) tick();
        chk("wrap_bin62", 32'(dbin), 62);
        chk("wrap_delta_hold", 32'(delta), 0);
        din = 6'b100000;
        repeat (3) tick();
        chk("wrap_bin63", 32'(dbin), 63);
        chk("wrap_delta63", 32'(delta), 1);
        din = 6'b000000;
        repeat (3) tick();
        chk("wrap_bin0", 32'(dbin), 0);
        chk("wrap_delta0", 32'(delta), 1);
        chk("wrap_err", 32'(serr), 0);

        // Scenario 4: hold, single-bit jump of 3, then a 3-bit gray step
        for (int i = 1; i <= 6; i++) begin
            din = b2g(i);
            tick();
        end
        repeat (10) tick();
        chk("hold_bin", 32'(dbin), 6);
        chk("hold_delta", 32'(delta), 0);
        chk("hold_sync", 32'(sync), 32'b000101);
        chk("hold_err", 32'(serr), 0);
        din = 6'b001101;
        repeat (3) tick();
        chk("jump_bin", 32'(dbin), 9);
        chk("jump_delta", 32'(delta), 3);
        tick();
        chk("jump_delta_after", 32'(delta), 0);
        chk("jump_1bit_err", 32'(serr), 0);
        din = 6'b000101;
        repeat (4) tick();
        chk("back_bin", 32'(dbin), 6);
        din = 6'b000010;
        repeat (3) tick();
        chk("bad_bin", 32'(dbin), 3);
        chk("bad_err", 32'(serr), EXP_JUMP_ERR);
        repeat (5) tick();
        chk("bad_err_held", 32'(serr), EXP_JUMP_ERR);
        #3 rst = 1'b1;
        #1;
        check_zero("err_clr");
        tick();
        rst = 1'b0;

        // Scenario 5: reset pulse in the middle of a sweep
        sweep(50, 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
